transition_pair_sequencer: RTL and testbench
============================================

# transition_pair_sequencer

Synthesizable stimulus-and-capture stage that sits directly upstream of the 3-gate masked module (inputs a, b, r1, r2, q; output y). It walks the full correlation campaign: for q in {0,1}, every ordered pair (i, j) of 4-bit vectors {a,b,r1,r2}. It holds i, then j, counts y transitions during the j window, and hands one result per pair downstream over a valid/ready handshake. This replaces delay-based stimulus with a cycle-exact, on-chip sequence of 512 transition windows.

## Interface
- HOLD_CYCLES, 5, cycles each vector (i, then j) is held; legal range 1..255
- CNT_W, 8, width of per-window toggle counter; saturating
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- start  in  1  begin campaign; sampled only in IDLE
- y  in  1  DUT output, combinational from a/b/r1/r2/q
- a, b, r1, r2  out  1 each  DUT data/mask inputs, registered
- q  out  1  DUT control input, registered
- win_begin  out  1  pulse: first cycle of j window
- win_end  out  1  pulse: last cycle of j window
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final result accepted
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_sim  out  9  pair index s = {q, i[3:0], j[3:0]}
- res_count  out  CNT_W  y toggles observed in j window

## Operation
- Pair index s (9 bits) in 0..511: q = s[8], i = s[7:4], j = s[3:0]; {a,b,r1,r2} is packed MSB-first (a = bit 3).
- States: IDLE, APPLY_I, APPLY_J, REPORT, DONE.
- IDLE: outputs low, s = 0. start=1 -> APPLY_I.
- APPLY_I: drive {a,b,r1,r2} = s[7:4], q = s[8] for HOLD_CYCLES cycles -> APPLY_J.
- APPLY_J: drive {a,b,r1,r2} = s[3:0], q unchanged, for HOLD_CYCLES cycles -> REPORT. Each cycle y != y_q (y registered every cycle in all states) increments count, saturating at 2^CNT_W-1. Count clears on entry to APPLY_I.
- REPORT: res_valid=1, res_sim=s, res_count stable; data inputs keep the j vector. On res_valid&&res_ready: s==511 -> DONE, else s+1 -> APPLY_I.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- win_begin/win_end are both high in the same cycle when HOLD_CYCLES=1.

## Timing
- Reset: all outputs 0, state IDLE, s=0, count=0, y_q=0. Reset mid-campaign aborts immediately; the next start restarts at s=0.
- start sampled at edge T -> first i vector and busy visible after T.
- Hold windows: i is visible for exactly HOLD_CYCLES cycles, then j for exactly HOLD_CYCLES cycles.
- First APPLY_J cycle compares y (under j) against y_q (last i cycle). This captures the i->j transition.
- REPORT is at least 1 cycle. With res_ready tied high, each pair takes 2*HOLD_CYCLES+1 cycles, and the campaign takes 512*(2*HOLD_CYCLES+1) cycles plus 1 DONE cycle.
- While res_valid is high and res_ready is low, res_sim, res_count, a/b/r1/r2 and q are frozen.
- done pulses in the cycle after the handshake for s=511. busy falls in the same cycle that done falls.

## Test plan
- Full run, y tied 0, HOLD=5, ready high: 512 results, res_sim 0..511 in order, all res_count=0. done fires once at cycle 1+512*11 after start.
- y = a^b combinational, HOLD=5: res_count=1 exactly when parity(i[3:2]) != parity(j[3:2]), else 0; for s=0x0C0 (i=0xC, j=0x0) count=0; for s=0x080 (i=0x8, j=0x0) count=1.
- Backpressure: res_ready low for 10 cycles at s=3 -> res_valid held and outputs frozen; s=4 starts the cycle after ready rises.
- Reset mid-op: rst during APPLY_J of s=100 -> next cycle all outputs 0, busy=0; a new start yields res_sim=0 first.
- Saturation: CNT_W=2, HOLD=5, y toggling every cycle -> res_count=3 for every pair.
- start pulsed while busy -> no effect on sequence or s; HOLD=1 -> win_begin and win_end coincide.

Source files
------------

// File: rtl/transition_pair_sequencer.sv
// transition_pair_sequencer: walks all 512 (q,i,j) transition windows, counts y toggles per j window, reports each over valid/ready
module transition_pair_sequencer #(
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             r1,
  output logic             r2,
  output logic             q,
  output logic             win_begin,
  output logic             win_end,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [8:0]       res_sim,
  output logic [CNT_W-1:0] res_count
);
  localparam logic [2:0] IDLE = 3'd0, APPLY_I = 3'd1, APPLY_J = 3'd2, REPORT = 3'd3, DONE = 3'd4;
  localparam logic [7:0] HL = 8'(HOLD_CYCLES - 1);
  logic [2:0] state;
  logic [8:0] s;
  logic [8:0] s_nx;
  logic [7:0] hcnt;
  logic [CNT_W-1:0] count;
  logic [3:0] vec;
  logic y_q;
  logic last;
  assign s_nx = s + 9'd1;
  assign last = hcnt == HL;
  assign {a, b, r1, r2} = vec;
  assign win_begin = state == APPLY_J && hcnt == 8'd0;
  assign win_end = state == APPLY_J && last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign res_valid = state == REPORT;
  assign res_sim = res_valid ? s : '0;
  assign res_count = res_valid ? count : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      hcnt <= '0;
      count <= '0;
      vec <= '0;
      q <= 1'b0;
      y_q <= 1'b0;
    end else begin
      y_q <= y;
      case (state)
        IDLE: if (start) begin
          state <= APPLY_I;
          hcnt <= '0;
          count <= '0;
          vec <= s[7:4];
          q <= s[8];
        end
        APPLY_I: if (last) begin
          state <= APPLY_J;
          hcnt <= '0;
          vec <= s[3:0];
        end else hcnt <= hcnt + 8'd1;
        APPLY_J: begin
          count <= (y != y_q && count != {CNT_W{1'b1}}) ? count + CNT_W'(1) : count;
          if (last) state <= REPORT;
          else hcnt <= hcnt + 8'd1;
        end
        REPORT: if (res_ready) begin
          if (s == 9'd511) begin
            state <= DONE;
            s <= '0;
            vec <= '0;
            q <= 1'b0;
          end else begin
            state <= APPLY_I;
            s <= s_nx;
            hcnt <= '0;
            count <= '0;
            vec <= s_nx[7:4];
            q <= s_nx[8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transition_pair_sequencer.sv
// tb_transition_pair_sequencer: directed self-checking bench for transition_pair_sequencer
module tb_transition_pair_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic mode = 1'b0;
  logic tgl = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic a0, b0, r10, r20, q0, wb0, we0, bz0, dn0, rv0;
  logic [8:0] rs0;
  logic [7:0] rc0;
  logic y0;
  logic a1, b1, r11, r21, q1, wb1, we1, bz1, dn1, rv1;
  logic [8:0] rs1;
  logic [1:0] rc1;
  logic a2, b2, r12, r22, q2, wb2, we2, bz2, dn2, rv2;
  logic [8:0] rs2;
  logic [7:0] rc2;
  always #5 clk = ~clk;
  always @(negedge clk) tgl <= ~tgl;
  assign y0 = mode ? a0 ^ b0 : 1'b0;
  transition_pair_sequencer #(.HOLD_CYCLES(5), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .y(y0), .a(a0), .b(b0), .r1(r10), .r2(r20), .q(q0),
    .win_begin(wb0), .win_end(we0), .busy(bz0), .done(dn0), .res_valid(rv0), .res_ready(ready),
    .res_sim(rs0), .res_count(rc0));
  transition_pair_sequencer #(.HOLD_CYCLES(5), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .y(tgl), .a(a1), .b(b1), .r1(r11), .r2(r21), .q(q1),
    .win_begin(wb1), .win_end(we1), .busy(bz1), .done(dn1), .res_valid(rv1), .res_ready(ready),
    .res_sim(rs1), .res_count(rc1));
  transition_pair_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .y(1'b0), .a(a2), .b(b2), .r1(r12), .r2(r22), .q(q2),
    .win_begin(wb2), .win_end(we2), .busy(bz2), .done(dn2), .res_valid(rv2), .res_ready(ready),
    .res_sim(rs2), .res_count(rc2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_res(input logic [8:0] idx, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (rv0 && rs0 == idx) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  function automatic logic [9:0] pack0();
    return {q0, a0, b0, r10, r20, wb0, we0, rv0, bz0, dn0};
  endfunction
  initial begin
    bit ok;
    logic [8:0] pv;
    logic [3:0] ev;
    int ph;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_u0", {pack0(), rs0, rc0}, 32'd0);
    check("reset_u1", {bz1, dn1, rv1}, 32'd0);
    check("reset_u2", {bz2, dn2, rv2}, 32'd0);
    start = 1'b1;
    for (int n = 0; n <= 5633; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 19) start = 1'b1;
      if (n == 20) start = 1'b0;
      pv = 9'(n / 11);
      ph = n % 11;
      ev = ph < 5 ? pv[7:4] : pv[3:0];
      if (n < 5632) check("seq", pack0(), {pv[8], ev, ph == 5, ph == 9, ph == 10, 1'b1, 1'b0});
      else check("end", pack0(), n == 5632 ? 10'b0000000011 : 10'd0);
      if (n < 5632 && ph == 10) begin
        check("res0", {rs0, rc0}, {pv, 8'd0});
        check("sat", {rs1, rc1}, {pv, 2'd3});
      end
      if (n < 1536) check("hold1_win", {wb2, we2}, n % 3 == 1 ? 2'b11 : 2'b00);
      if (n == 1536) check("hold1_done", {dn2, bz2}, 2'b11);
    end
    mode = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 5632; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      pv = 9'(n / 11);
      if (n % 11 == 10) check("parity", {rv0, rs0, rc0}, {1'b1, pv, 7'd0, (pv[7] ^ pv[6]) != (pv[3] ^ pv[2])});
    end
    @(negedge clk);
    @(negedge clk);
    check("idle2", bz0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_res(9'd3, 100, ok);
    check("wait_s3", ok, 1'b1);
    ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", {rv0, rs0, rc0, q0, a0, b0, r10, r20}, {1'b1, 9'd3, 8'd0, 1'b0, 4'b0011});
    end
    ready = 1'b1;
    @(negedge clk);
    check("s4_i", {rv0, bz0, q0, a0, b0, r10, r20}, {1'b0, 1'b1, 1'b0, 4'b0000});
    repeat (5) @(negedge clk);
    check("s4_j", {wb0, a0, b0, r10, r20}, {1'b1, 4'b0100});
    wait_res(9'd99, 2000, ok);
    check("wait_s99", ok, 1'b1);
    repeat (7) @(negedge clk);
    check("s100_j", {wb0, we0, q0, a0, b0, r10, r20}, {2'b00, 1'b0, 4'b0100});
    rst = 1'b1;
    @(negedge clk);
    check("midrst", {pack0(), rs0, rc0}, 32'd0);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_res(9'd0, 20, ok);
    check("restart_s0", {ok, rs0, rc0}, {1'b1, 9'd0, 8'd0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
